// File: rtl/tl_xbar_pkg.sv
// tl_xbar_pkg: TileLink-UL opcodes and sizing helpers shared by the N:1 crossbar.
package tl_xbar_pkg;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  function automatic int clog2(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  // Puts larger than the bus width span 2^size/bytes beats; everything else is one beat.
  function automatic logic [31:0] beats_from_size(input logic [2:0] opcode, input int unsigned size, input int unsigned lg_bytes);
    return ((opcode == PUT_FULL || opcode == PUT_PARTIAL) && size > lg_bytes) ? 32'd1 << (size - lg_bytes) : 32'd1;
  endfunction
endpackage

// File: rtl/tl_xbar_nto1_arb.sv
// tl_rr_arbiter: N-way round-robin grant with a sticky owner override.
module tl_rr_arbiter import tl_xbar_pkg::*; #(
  parameter int N = 2,
  parameter int W = clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         hold,
  input  logic [W-1:0] owner,
  input  logic         advance,
  output logic [W-1:0] grant
);
  logic [W-1:0] rr_ptr, scan, c;
  // Scan downward so the client nearest rr_ptr is the last (winning) write.
  always_comb begin
    scan = rr_ptr;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = W'((int'(rr_ptr) + k) % N);
      if (req[c]) scan = c;
    end
  end
  assign grant = hold ? owner : scan;
  always_ff @(posedge clock or posedge reset)
    if (reset) rr_ptr <= '0;
    else if (advance) rr_ptr <= (grant == W'(N - 1)) ? '0 : grant + 1'b1;
endmodule

// File: rtl/tl_xbar_nto1.sv
// tl_xbar_nto1: N-to-1 TileLink-UL crossbar; round-robin A with burst lock and source prefixing, D steered by prefix.
// Define TL_XBAR_PERF_EN to get saturating per-client first-beat grant counters on perf_grants.
module tl_xbar_nto1 import tl_xbar_pkg::*; #(
  parameter int N_IN = 2,
  parameter int SRC_W = 3,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 4,
  localparam int PFX_W = clog2(N_IN),
  localparam int OSRC_W = SRC_W + PFX_W,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          in_a_valid,
  output logic [N_IN-1:0]          in_a_ready,
  input  logic [3*N_IN-1:0]        in_a_opcode,
  input  logic [3*N_IN-1:0]        in_a_param,
  input  logic [SIZE_W*N_IN-1:0]   in_a_size,
  input  logic [SRC_W*N_IN-1:0]    in_a_source,
  input  logic [ADDR_W*N_IN-1:0]   in_a_address,
  input  logic [MASK_W*N_IN-1:0]   in_a_mask,
  input  logic [DATA_W*N_IN-1:0]   in_a_data,
  input  logic [N_IN-1:0]          in_a_corrupt,
  output logic [N_IN-1:0]          in_d_valid,
  input  logic [N_IN-1:0]          in_d_ready,
  output logic [2:0]               in_d_opcode,
  output logic [1:0]               in_d_param,
  output logic [SIZE_W-1:0]        in_d_size,
  output logic [SRC_W-1:0]         in_d_source,
  output logic                     in_d_sink,
  output logic                     in_d_denied,
  output logic [DATA_W-1:0]        in_d_data,
  output logic                     in_d_corrupt,
  output logic                     out_a_valid,
  input  logic                     out_a_ready,
  output logic [2:0]               out_a_opcode,
  output logic [2:0]               out_a_param,
  output logic [SIZE_W-1:0]        out_a_size,
  output logic [OSRC_W-1:0]        out_a_source,
  output logic [ADDR_W-1:0]        out_a_address,
  output logic [MASK_W-1:0]        out_a_mask,
  output logic [DATA_W-1:0]        out_a_data,
  output logic                     out_a_corrupt,
  input  logic                     out_d_valid,
  output logic                     out_d_ready,
  input  logic [2:0]               out_d_opcode,
  input  logic [1:0]               out_d_param,
  input  logic [SIZE_W-1:0]        out_d_size,
  input  logic [OSRC_W-1:0]        out_d_source,
  input  logic                     out_d_sink,
  input  logic                     out_d_denied,
  input  logic [DATA_W-1:0]        out_d_data,
  input  logic                     out_d_corrupt,
  output logic [32*N_IN-1:0]       perf_grants
);
  logic locked, hold, fire, first_fire, d_legal;
  logic [PFX_W-1:0] owner, grant, d_idx;
  logic [31:0] beats_left, beats;
  tl_rr_arbiter #(.N(N_IN), .W(PFX_W)) u_arb (
    .clock(clock), .reset(reset), .req(in_a_valid), .hold(locked || hold),
    .owner(owner), .advance(first_fire), .grant(grant)
  );
  assign out_a_valid = !reset && in_a_valid[grant];
  assign fire = out_a_valid && out_a_ready;
  assign first_fire = fire && !locked;
  assign in_a_ready = fire ? N_IN'(1) << grant : '0;
  assign out_a_opcode = in_a_opcode[3*grant +: 3];
  assign out_a_param = in_a_param[3*grant +: 3];
  assign out_a_size = in_a_size[SIZE_W*grant +: SIZE_W];
  assign out_a_source = {grant, in_a_source[SRC_W*grant +: SRC_W]};
  assign out_a_address = in_a_address[ADDR_W*grant +: ADDR_W];
  assign out_a_mask = in_a_mask[MASK_W*grant +: MASK_W];
  assign out_a_data = in_a_data[DATA_W*grant +: DATA_W];
  assign out_a_corrupt = in_a_corrupt[grant];
  assign beats = beats_from_size(out_a_opcode, 32'(out_a_size), $clog2(MASK_W));
  // A stalled beat pins the grant; a multi-beat put pins it until its last beat fires.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      locked <= 1'b0;
      hold <= 1'b0;
      owner <= '0;
      beats_left <= '0;
    end else if (out_a_valid && !out_a_ready) begin
      hold <= 1'b1;
      owner <= grant;
    end else if (fire) begin
      hold <= 1'b0;
      if (locked) begin
        beats_left <= beats_left - 1;
        locked <= beats_left != 32'd1;
      end else if (beats > 32'd1) begin
        locked <= 1'b1;
        owner <= grant;
        beats_left <= beats - 1;
      end
    end
  assign d_idx = out_d_source[OSRC_W-1:SRC_W];
  assign d_legal = int'(d_idx) < N_IN;
  // Responses for a nonexistent prefix are swallowed so the manager never stalls.
  assign in_d_valid = (d_legal && out_d_valid) ? N_IN'(1) << d_idx : '0;
  assign out_d_ready = !d_legal || in_d_ready[d_idx];
  assign in_d_opcode = out_d_opcode;
  assign in_d_param = out_d_param;
  assign in_d_size = out_d_size;
  assign in_d_source = out_d_source[SRC_W-1:0];
  assign in_d_sink = out_d_sink;
  assign in_d_denied = out_d_denied;
  assign in_d_data = out_d_data;
  assign in_d_corrupt = out_d_corrupt;
`ifdef TL_XBAR_PERF_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_perf
    logic [31:0] cnt;
    always_ff @(posedge clock or posedge reset)
      if (reset) cnt <= '0;
      else if (first_fire && grant == PFX_W'(i) && cnt != '1) cnt <= cnt + 1;
    assign perf_grants[32*i +: 32] = cnt;
  end
`else
  assign perf_grants = '0;
`endif
endmodule

// File: tb/tb_tl_xbar_nto1.sv
// tb_tl_xbar_nto1: D routing table, hand-written A corner sequences and a randomized run against a behavioural model.
module tb_tl_xbar_nto1;
  import tl_xbar_pkg::*;
  localparam int N = 2;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] in_a_valid, in_a_ready, in_a_corrupt, in_d_valid, in_d_ready;
  logic [5:0] in_a_opcode, in_a_param, in_a_source;
  logic [7:0] in_a_size;
  logic [61:0] in_a_address;
  logic [15:0] in_a_mask;
  logic [127:0] in_a_data;
  logic [2:0] in_d_opcode, in_d_source;
  logic [1:0] in_d_param;
  logic [3:0] in_d_size;
  logic in_d_sink, in_d_denied, in_d_corrupt;
  logic [63:0] in_d_data;
  logic out_a_valid, out_a_ready, out_a_corrupt;
  logic [2:0] out_a_opcode, out_a_param;
  logic [3:0] out_a_size, out_a_source;
  logic [30:0] out_a_address;
  logic [7:0] out_a_mask;
  logic [63:0] out_a_data;
  logic out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
  logic [2:0] out_d_opcode;
  logic [1:0] out_d_param;
  logic [3:0] out_d_size, out_d_source;
  logic [63:0] out_d_data;
  logic [63:0] perf_grants;
  // Three-client instance, used only for D-channel prefix range checks.
  logic [2:0] t_a_ready, t_d_valid, t_d_ready, t_d_opcode, t_d_source, t_a_opcode, t_a_param;
  logic [1:0] t_d_param;
  logic [3:0] t_d_size, t_a_size;
  logic t_d_sink, t_d_denied, t_d_corrupt, t_a_valid, t_a_corrupt, t_od_valid, t_od_ready;
  logic [63:0] t_d_data, t_a_data;
  logic [4:0] t_a_source, t_od_source;
  logic [30:0] t_a_address;
  logic [7:0] t_a_mask;
  logic [95:0] t_perf;

  tl_xbar_nto1 dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode), .in_a_param(in_a_param),
    .in_a_size(in_a_size), .in_a_source(in_a_source), .in_a_address(in_a_address), .in_a_mask(in_a_mask),
    .in_a_data(in_a_data), .in_a_corrupt(in_a_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode), .in_d_param(in_d_param),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_sink(in_d_sink), .in_d_denied(in_d_denied),
    .in_d_data(in_d_data), .in_d_corrupt(in_d_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address), .out_a_mask(out_a_mask),
    .out_a_data(out_a_data), .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_sink(out_d_sink), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data), .out_d_corrupt(out_d_corrupt),
    .perf_grants(perf_grants)
  );

  tl_xbar_nto1 #(.N_IN(3)) dut3 (
    .clock(clock), .reset(reset),
    .in_a_valid(3'b000), .in_a_ready(t_a_ready), .in_a_opcode(9'd0), .in_a_param(9'd0),
    .in_a_size(12'd0), .in_a_source(9'd0), .in_a_address(93'd0), .in_a_mask(24'd0),
    .in_a_data(192'd0), .in_a_corrupt(3'b000),
    .in_d_valid(t_d_valid), .in_d_ready(t_d_ready), .in_d_opcode(t_d_opcode), .in_d_param(t_d_param),
    .in_d_size(t_d_size), .in_d_source(t_d_source), .in_d_sink(t_d_sink), .in_d_denied(t_d_denied),
    .in_d_data(t_d_data), .in_d_corrupt(t_d_corrupt),
    .out_a_valid(t_a_valid), .out_a_ready(1'b0), .out_a_opcode(t_a_opcode), .out_a_param(t_a_param),
    .out_a_size(t_a_size), .out_a_source(t_a_source), .out_a_address(t_a_address), .out_a_mask(t_a_mask),
    .out_a_data(t_a_data), .out_a_corrupt(t_a_corrupt),
    .out_d_valid(t_od_valid), .out_d_ready(t_od_ready), .out_d_opcode(3'd1), .out_d_param(2'd0),
    .out_d_size(4'd3), .out_d_source(t_od_source), .out_d_sink(1'b0), .out_d_denied(1'b0),
    .out_d_data(64'd0), .out_d_corrupt(1'b0),
    .perf_grants(t_perf)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  bit act[N];
  logic [2:0] op[N], src[N];
  logic [3:0] sz[N];
  logic [30:0] adr[N];
  logic [63:0] dat[N];
  int sent[N], tot[N], perf_m[N];
  int rr, pg, g, r;
  bit stl, ev;
  logic [1:0] exp_rdy;

  typedef struct {
    logic [3:0] osrc;
    logic dv;
    logic [1:0] drdy;
    logic [1:0] exp_dv;
    logic exp_rdy;
    logic [2:0] exp_src;
  } dvec_t;
  dvec_t tbl[6];
  logic [3:0] alt[4];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic int nbeats(input logic [2:0] o, input logic [3:0] s);
    int b;
    b = (1 << s) / 8;
    return (o == PUT_FULL || o == PUT_PARTIAL) && b > 1 ? b : 1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_a_valid[i] = act[i];
      in_a_opcode[3*i +: 3] = op[i];
      in_a_size[4*i +: 4] = sz[i];
      in_a_source[3*i +: 3] = src[i];
      in_a_address[31*i +: 31] = adr[i];
      in_a_data[64*i +: 64] = dat[i];
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [3:0] s, input logic [2:0] sr);
    act[i] = 1'b1; op[i] = o; sz[i] = s; src[i] = sr;
    adr[i] = 31'($urandom); dat[i] = {$urandom, $urandom};
    sent[i] = 0; tot[i] = nbeats(o, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; sent[i] = 0; perf_m[i] = 0; end
    rr = 0; stl = 1'b0; out_a_ready = 1'b0; out_d_valid = 1'b0;
    drive();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_a_param = '0; in_a_mask = '1; in_a_corrupt = '0;
    out_d_opcode = ACCESS_ACK_DATA; out_d_param = '0; out_d_size = 4'd3; out_d_sink = 1'b0;
    out_d_denied = 1'b0; out_d_data = 64'h0123_4567_89ab_cdef; out_d_corrupt = 1'b0;
    out_d_valid = 1'b0; out_d_source = '0; in_d_ready = '0; out_a_ready = 1'b1;
    t_od_valid = 1'b0; t_od_source = '0; t_d_ready = '0;
    for (int i = 0; i < N; i++) set_req(i, GET, 4'd3, 3'(i));
    drive();
    #1;
    chk("reset_a_valid", out_a_valid, 1'b0);
    chk("reset_a_ready", in_a_ready, 2'b00);
    chk("reset_perf", perf_grants, 64'd0);
    do_reset();

    // D routing table (combinational)
    tbl[0] = '{4'b1010, 1'b1, 2'b00, 2'b10, 1'b0, 3'b010};
    tbl[1] = '{4'b1010, 1'b1, 2'b10, 2'b10, 1'b1, 3'b010};
    tbl[2] = '{4'b0111, 1'b1, 2'b01, 2'b01, 1'b1, 3'b111};
    tbl[3] = '{4'b0111, 1'b1, 2'b10, 2'b01, 1'b0, 3'b111};
    tbl[4] = '{4'b1001, 1'b0, 2'b11, 2'b00, 1'b1, 3'b001};
    tbl[5] = '{4'b0000, 1'b0, 2'b10, 2'b00, 1'b0, 3'b000};
    for (int i = 0; i < 6; i++) begin
      out_d_source = tbl[i].osrc; out_d_valid = tbl[i].dv; in_d_ready = tbl[i].drdy;
      #1;
      chk($sformatf("d_vec%0d", i), {in_d_valid, out_d_ready, in_d_source}, {tbl[i].exp_dv, tbl[i].exp_rdy, tbl[i].exp_src});
    end
    chk("d_data", {in_d_opcode, in_d_data}, {ACCESS_ACK_DATA, 64'h0123_4567_89ab_cdef});
    out_d_valid = 1'b0;

    // three-client instance: prefix 3 is illegal and dropped, prefix 2 routes
    t_od_valid = 1'b1; t_od_source = 5'b11_010; t_d_ready = 3'b000;
    #1;
    chk("n3_illegal", {t_d_valid, t_od_ready}, {3'b000, 1'b1});
    t_od_source = 5'b10_110; t_d_ready = 3'b100;
    #1;
    chk("n3_legal", {t_d_valid, t_od_ready, t_d_source}, {3'b100, 1'b1, 3'b110});
    t_d_ready = 3'b011;
    #1;
    chk("n3_legal_stall", {t_d_valid, t_od_ready}, {3'b100, 1'b0});

    // two clients streaming Gets alternate
    do_reset();
    set_req(0, GET, 4'd3, 3'b101); set_req(1, GET, 4'd2, 3'b011);
    out_a_ready = 1'b1; drive();
    alt[0] = 4'b0101; alt[1] = 4'b1011; alt[2] = 4'b0101; alt[3] = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("alt%0d", c), {out_a_valid, out_a_source}, {1'b1, alt[c]});
      @(posedge clock); #1;
    end

    // four-beat PutFull from client 1 locks out client 0
    do_reset();
    set_req(1, PUT_FULL, 4'd5, 3'b010);
    out_a_ready = 1'b1; drive();
    for (int b = 0; b < 5; b++) begin
      @(negedge clock);
      chk($sformatf("burst%0d", b), out_a_source, b < 4 ? 4'b1010 : 4'b0001);
      @(posedge clock); #1;
      if (b == 0) set_req(0, GET, 4'd3, 3'b001);
      if (b == 3) act[1] = 1'b0;
      drive();
    end

    // stalled grant stays put while rr favours the other client
    do_reset();
    set_req(0, GET, 4'd3, 3'b000);
    out_a_ready = 1'b1; drive();
    @(negedge clock);
    chk("stall_pre", out_a_source, 4'b0000);
    @(posedge clock); #1;
    set_req(0, GET, 4'd3, 3'b110); adr[0] = 31'h1234567;
    out_a_ready = 1'b0; drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("stall_src%0d", c), {out_a_valid, out_a_source, out_a_address}, {1'b1, 4'b0110, 31'h1234567});
      chk($sformatf("stall_rdy%0d", c), in_a_ready, 2'b00);
      @(posedge clock); #1;
      if (c == 0) begin set_req(1, GET, 4'd3, 3'b001); drive(); end
    end
    out_a_ready = 1'b1; drive();
    @(negedge clock);
    chk("stall_fire", {in_a_ready, out_a_source}, {2'b01, 4'b0110});
    @(posedge clock); #1;
    act[0] = 1'b0; drive();
    @(negedge clock);
    chk("stall_next", {in_a_ready, out_a_source}, {2'b10, 4'b1001});
    @(posedge clock); #1;

    // reset in the middle of a burst
    do_reset();
    set_req(0, PUT_FULL, 4'd5, 3'b011); set_req(1, GET, 4'd3, 3'b100);
    out_a_ready = 1'b1; drive();
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      chk($sformatf("pre_rst%0d", b), out_a_source, 4'b0011);
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", out_a_valid, 1'b0);
    chk("rst_mid_ready", in_a_ready, 2'b00);
    chk("rst_mid_perf", perf_grants, 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    set_req(0, GET, 4'd3, 3'b101); drive();
    #1;
    chk("post_rst_first", {in_a_ready, out_a_source}, {2'b01, 4'b0101});
    @(posedge clock); #1;
    @(negedge clock);
    chk("post_rst_unlocked", {in_a_ready, out_a_source}, {2'b10, 4'b1100});
    @(posedge clock); #1;

    // randomized traffic against the behavioural model
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!act[i] && $urandom_range(0, 2) != 0) begin
          r = $urandom_range(0, 2);
          set_req(i, r == 0 ? GET : 3'(r - 1), 4'($urandom_range(0, 5)), 3'($urandom));
        end
      out_a_ready = $urandom_range(0, 3) != 0;
      out_d_valid = 1'($urandom); out_d_source = 4'($urandom); in_d_ready = 2'($urandom);
      drive();
      @(negedge clock);
      // a part-sent burst owns the port; else a stalled client; else first valid from rr
      g = -1;
      for (int i = 0; i < N; i++) if (act[i] && sent[i] > 0) g = i;
      if (g < 0 && stl) g = pg;
      if (g < 0) for (int k = N - 1; k >= 0; k--) if (act[(rr + k) % N]) g = (rr + k) % N;
      ev = g >= 0;
      exp_rdy = (ev && out_a_ready) ? 2'(1 << g) : 2'b00;
      chk("rnd_a_valid", out_a_valid, ev);
      chk("rnd_a_ready", in_a_ready, exp_rdy);
      if (ev) chk("rnd_a_fields", {out_a_source, out_a_opcode, out_a_size, out_a_address, out_a_data},
                  {g[0], src[g], op[g], sz[g], adr[g], dat[g]});
      chk("rnd_d_route", {in_d_valid, out_d_ready, in_d_source},
          {out_d_valid ? 2'(1 << out_d_source[3]) : 2'b00, in_d_ready[out_d_source[3]], out_d_source[2:0]});
      stl = ev && !out_a_ready;
      pg = g;
      if (ev && out_a_ready) begin
        if (sent[g] == 0) begin perf_m[g]++; rr = (g + 1) % N; end
        sent[g]++;
        dat[g] = {$urandom, $urandom};
        if (sent[g] == tot[g]) begin act[g] = 1'b0; sent[g] = 0; end
      end
      @(posedge clock); #1;
    end
`ifdef TL_XBAR_PERF_EN
    for (int i = 0; i < N; i++) chk($sformatf("perf%0d", i), perf_grants[32*i +: 32], 32'(perf_m[i]));
`else
    chk("perf_off", perf_grants, 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
